// File: rtl/crypt_stream_if.sv
// Host-side stream/config bundle for crypt_stream_engine.
// master = host/link driver side, slave = the engine.
interface crypt_stream_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic          en;
  logic          cfg_wen;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic          cfg_err;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;

  modport master (
    output en, cfg_wen, cfg_addr, cfg_data, in_valid, in_data, in_last, out_ready,
    input  cfg_err, in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  en, cfg_wen, cfg_addr, cfg_data, in_valid, in_data, in_last, out_ready,
    output cfg_err, in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/crypt_stream_engine.sv
// Framed XOR/rotate stream cipher with rotating key bank and output FIFO.
// Optional macro CSE_FRAME_CNT_EN adds a 16-bit completed-frame counter port.
module crypt_stream_engine #(
  parameter int DW         = 8,
  parameter int NKEYS      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  crypt_stream_if.slave bus
`ifdef CSE_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);
  localparam int AW    = $clog2(NKEYS + 1);
  localparam int KW    = $clog2(NKEYS);
  localparam int SW    = $clog2(DW);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int CTRLW = 2 + SW + 4;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state_reg, state_next;

  logic [DW-1:0]    key_reg [NKEYS];
  logic [CTRLW-1:0] ctrl_reg, ctrl_wdata;
  logic [KW-1:0]    idx_reg;
  logic [3:0]       cnt_reg;
  logic             cfg_err_reg;

  logic [DW:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;

  logic             accept, pop, cfg_ok, addr_valid, ctrl_we;
  logic [NKEYS-1:0] key_we;
  logic             mode, shift_en;
  logic [SW-1:0]    shift_amt;
  logic [3:0]       rot_freq;
  logic [DW-1:0]    key_cur, mixed, y;

  function automatic logic [DW-1:0] rotl(input logic [DW-1:0] v, input logic [SW-1:0] a);
    return (v << a) | (v >> (DW - int'(a)));
  endfunction

  function automatic logic [DW-1:0] rotr(input logic [DW-1:0] v, input logic [SW-1:0] a);
    return (v >> a) | (v << (DW - int'(a)));
  endfunction

  assign bus.in_ready  = bus.en && (count_reg < CW'(FIFO_DEPTH));
  assign bus.out_valid = (count_reg != '0);
  assign accept        = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;
  assign {bus.out_last, bus.out_data} = fifo_mem[rd_ptr_reg];
  assign bus.cfg_err   = cfg_err_reg;

  // Writes only land between frames and never in a cycle that also consumes a beat.
  assign addr_valid = (bus.cfg_addr <= AW'(NKEYS));
  assign cfg_ok     = bus.cfg_wen && (state_reg == IDLE) && !accept;
  assign ctrl_we    = cfg_ok && (bus.cfg_addr == AW'(NKEYS));

  generate
    for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key_we
      assign key_we[gi] = cfg_ok && (bus.cfg_addr == AW'(gi));
    end
    // The rot_freq field may extend past DW; missing upper bits read as zero.
    if (DW >= CTRLW) begin : g_ctrl_narrow
      assign ctrl_wdata = bus.cfg_data[CTRLW-1:0];
    end else begin : g_ctrl_wide
      assign ctrl_wdata = {{(CTRLW-DW){1'b0}}, bus.cfg_data};
    end
  endgenerate

  assign mode      = ctrl_reg[0];
  assign shift_en  = ctrl_reg[1];
  assign shift_amt = ctrl_reg[2 +: SW];
  assign rot_freq  = ctrl_reg[2+SW +: 4];

  always_comb begin
    key_cur = key_reg[idx_reg];
    mixed   = bus.in_data ^ key_cur;
    y       = mixed;
    if (shift_en) begin
      y = mode ? (rotr(bus.in_data, shift_amt) ^ key_cur) : rotl(mixed, shift_amt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NKEYS; i++) key_reg[i] <= '0;
      ctrl_reg    <= '0;
      cfg_err_reg <= 1'b0;
    end else begin
      for (int i = 0; i < NKEYS; i++) begin
        if (key_we[i]) key_reg[i] <= bus.cfg_data;
      end
      if (ctrl_we) ctrl_reg <= ctrl_wdata;
      cfg_err_reg <= bus.cfg_wen && addr_valid && !cfg_ok;
    end
  end

  // Key schedule restarts at key 0 after every frame end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg <= '0;
      cnt_reg <= '0;
    end else if (accept) begin
      if (bus.in_last) begin
        idx_reg <= '0;
        cnt_reg <= '0;
      end else if (cnt_reg == rot_freq) begin
        cnt_reg <= '0;
        idx_reg <= (idx_reg == KW'(NKEYS - 1)) ? '0 : idx_reg + 1'b1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr_reg] <= {bus.in_last, y};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({accept, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (accept) state_next = bus.in_last ? IDLE : RUN;
  end

  always_comb begin
    bus.busy = (state_reg == RUN);
  end

`ifdef CSE_FRAME_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      frame_cnt <= '0;
    else if (accept && bus.in_last) frame_cnt <= frame_cnt + 16'd1;
  end
`endif
endmodule
